// File: rtl/seq_approx_div_pkg.sv
// Shared types and helpers for the sequential approximate divider.
//   state_t      : controller states IDLE / BUSY / DONE
//   exact_cell   : full-subtractor cell, returns {bout, diff}
//   approx_cell  : approximate subtractor cell, returns {bout, diff}
//   widths_ok    : elaboration-time parameter sanity check
package seq_approx_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic bin);
        logic diff;
        logic bout;
        diff = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        return {bout, diff};
    endfunction

    // Cheap cell: the borrow simply alternates along the chain, so the
    // carry path is a chain of inverters instead of a majority function.
    function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic bin);
        logic diff;
        logic bout;
        diff = x | (y ^ bin);
        bout = ~bin;
        return {bout, diff};
    endfunction

    // Dividend must be wider than divisor, the row needs at least two
    // columns, and approximate rows cannot exceed the quotient width.
    function automatic bit widths_ok(input int n_w, input int d_w, input int approx_rows);
        return (n_w > d_w) && (d_w >= 2) && (approx_rows >= 0) && (approx_rows <= n_w - d_w);
    endfunction

endpackage

// File: rtl/seq_approx_divider_row.sv
// One restoring-division row: D_WIDTH-bit subtractor cell chain.
//   p      : in  current partial remainder
//   n_bit  : in  dividend bit shifted into the trial value
//   y      : in  divisor
//   approx : in  1 = approximate cells for the whole row
//   p_next : out partial remainder after this row
//   q_bit  : out quotient bit produced by this row
module div_sub_row
    import seq_approx_div_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic [D_WIDTH-1:0] p,
    input  logic               n_bit,
    input  logic [D_WIDTH-1:0] y,
    input  logic               approx,
    output logic [D_WIDTH-1:0] p_next,
    output logic               q_bit
);

    logic [D_WIDTH-1:0] x;
    logic [D_WIDTH-1:0] diff;
    logic [D_WIDTH:0]   borrow;

    assign x         = {p[D_WIDTH-2:0], n_bit};
    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < D_WIDTH; gi++) begin : g_col
            logic [1:0] e_cell;
            logic [1:0] a_cell;
            assign e_cell = exact_cell(x[gi], y[gi], borrow[gi]);
            assign a_cell = approx_cell(x[gi], y[gi], borrow[gi]);
            assign {borrow[gi+1], diff[gi]} = approx ? a_cell : e_cell;
        end
    endgenerate

    // The bit shifted out of P acts as a ninth trial bit: if it is set the
    // trial value is certainly >= divisor, whatever the borrow says.
    assign q_bit  = p[D_WIDTH-1] | ~borrow[D_WIDTH];
    assign p_next = q_bit ? diff : x;

endmodule

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider, one quotient bit per clock, with optional
// approximate cells on the APPROX_ROWS least-significant quotient rows.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (n, d, approx_en)
//   out_valid/out_ready : result handshake (q, r, ovf, dbz)
//   ovf                 : top D_WIDTH bits of n >= d (also set when d == 0)
//   dbz                 : divisor is zero
// Optional macro SEQ_APPROX_DIV_SHADOW_EN adds an always-exact shadow row
// and the ports q_exact, r_exact and err.
module seq_approx_divider
    import seq_approx_div_pkg::*;
#(
    parameter int N_WIDTH     = 16,
    parameter int D_WIDTH     = 8,
    parameter int APPROX_ROWS = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_WIDTH-1:0]         n,
    input  logic [D_WIDTH-1:0]         d,
    input  logic                       approx_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_WIDTH-D_WIDTH-1:0] q,
    output logic [D_WIDTH-1:0]         r,
    output logic                       ovf,
`ifdef SEQ_APPROX_DIV_SHADOW_EN
    output logic [N_WIDTH-D_WIDTH-1:0] q_exact,
    output logic [D_WIDTH-1:0]         r_exact,
    output logic                       err,
`endif
    output logic                       dbz
);

    localparam int Q_WIDTH = N_WIDTH - D_WIDTH;
    localparam int K_W     = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
    localparam bit CFG_OK  = widths_ok(N_WIDTH, D_WIDTH, APPROX_ROWS);

    localparam logic [K_W-1:0] K_LAST     = K_W'(Q_WIDTH - 1);
    localparam logic [K_W:0]   APPROX_LIM = (K_W + 1)'(APPROX_ROWS);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("seq_approx_divider: illegal N_WIDTH/D_WIDTH/APPROX_ROWS");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [Q_WIDTH-1:0] n_q, n_d;       // only the bits fed into rows are kept
    logic [D_WIDTH-1:0] d_q, d_d;
    logic               approx_q, approx_d;
    logic [D_WIDTH-1:0] p_q, p_d;
    logic [Q_WIDTH-1:0] q_q, q_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    logic [D_WIDTH-1:0] row_p;
    logic               row_q;
    logic               row_approx;
    logic [D_WIDTH-1:0] n_top;

    assign n_top      = n[N_WIDTH-1 -: D_WIDTH];
    assign row_approx = approx_q && ({1'b0, k_q} < APPROX_LIM);

    div_sub_row #(.D_WIDTH(D_WIDTH)) u_row (
        .p      (p_q),
        .n_bit  (n_q[k_q]),
        .y      (d_q),
        .approx (row_approx),
        .p_next (row_p),
        .q_bit  (row_q)
    );

`ifdef SEQ_APPROX_DIV_SHADOW_EN
    logic [D_WIDTH-1:0] ps_q, ps_d;
    logic [Q_WIDTH-1:0] qs_q, qs_d;
    logic [D_WIDTH-1:0] srow_p;
    logic               srow_q;

    div_sub_row #(.D_WIDTH(D_WIDTH)) u_shadow_row (
        .p      (ps_q),
        .n_bit  (n_q[k_q]),
        .y      (d_q),
        .approx (1'b0),
        .p_next (srow_p),
        .q_bit  (srow_q)
    );
`endif

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        d_d      = d_q;
        approx_d = approx_q;
        p_d      = p_q;
        q_d      = q_q;
        k_d      = k_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
`ifdef SEQ_APPROX_DIV_SHADOW_EN
        ps_d     = ps_q;
        qs_d     = qs_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d      = n[Q_WIDTH-1:0];
                    d_d      = d;
                    approx_d = approx_en;
                    p_d      = n_top;
                    q_d      = '0;
                    k_d      = K_LAST;
                    ovf_d    = (n_top >= d);   // d == 0 makes this true as well
                    dbz_d    = (d == '0);
`ifdef SEQ_APPROX_DIV_SHADOW_EN
                    ps_d     = n_top;
                    qs_d     = '0;
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                p_d      = row_p;
                q_d[k_q] = row_q;
`ifdef SEQ_APPROX_DIV_SHADOW_EN
                ps_d      = srow_p;
                qs_d[k_q] = srow_q;
`endif
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            d_q      <= '0;
            approx_q <= 1'b0;
            p_q      <= '0;
            q_q      <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef SEQ_APPROX_DIV_SHADOW_EN
            ps_q     <= '0;
            qs_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            d_q      <= d_d;
            approx_q <= approx_d;
            p_q      <= p_d;
            q_q      <= q_d;
            k_q      <= k_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
`ifdef SEQ_APPROX_DIV_SHADOW_EN
            ps_q     <= ps_d;
            qs_q     <= qs_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign r         = p_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;
`ifdef SEQ_APPROX_DIV_SHADOW_EN
    assign q_exact   = qs_q;
    assign r_exact   = ps_q;
    assign err       = (q_q != qs_q) | (p_q != ps_q);
`endif

endmodule

// File: tb/tb_seq_approx_divider.sv
module tb_seq_approx_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
`ifdef SEQ_APPROX_DIV_SHADOW_EN
    logic [7:0]  q_exact;
    logic [7:0]  r_exact;
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_approx_divider #(.N_WIDTH(16), .D_WIDTH(8), .APPROX_ROWS(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
`ifdef SEQ_APPROX_DIV_SHADOW_EN
        .q_exact   (q_exact),
        .r_exact   (r_exact),
        .err       (err),
`endif
        .dbz       (dbz)
    );

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic        ae;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
        logic [7:0]  qe;
        logic [7:0]  re;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand set, let it be accepted, then wait (bounded) for out_valid.
    task automatic run_op(input logic [15:0] nv, input logic [7:0] dv, input logic ae, output int lat);
        @(negedge clk);
        n = nv; d = dv; approx_en = ae; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        approx_en = ~ae;   // must not matter after accept
        n = ~nv; d = ~dv;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] hq, hr;

        //            n        d      ae    q      r      ovf   dbz   qe     re     err
        vecs[0] = '{16'd1000, 8'd10, 1'b0, 8'h64, 8'h00, 1'b0, 1'b0, 8'h64, 8'h00, 1'b0};
        vecs[1] = '{16'd200,  8'd7,  1'b0, 8'd28, 8'd4,  1'b0, 1'b0, 8'd28, 8'd4,  1'b0};
        vecs[2] = '{16'd12345,8'd100,1'b0, 8'd123,8'd45, 1'b0, 1'b0, 8'd123,8'd45, 1'b0};
        vecs[3] = '{16'hFEFF, 8'hFF, 1'b0, 8'hFF, 8'hFE, 1'b0, 1'b0, 8'hFF, 8'hFE, 1'b0};
        vecs[4] = '{16'h00FF, 8'd3,  1'b0, 8'd85, 8'd0,  1'b0, 1'b0, 8'd85, 8'd0,  1'b0};
        vecs[5] = '{16'h0000, 8'd1,  1'b1, 8'h3F, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{16'h0A00, 8'h05, 1'b0, 8'hFF, 8'h05, 1'b1, 1'b0, 8'hFF, 8'h05, 1'b0};
        vecs[7] = '{16'h1234, 8'h00, 1'b0, 8'hFF, 8'h34, 1'b1, 1'b1, 8'hFF, 8'h34, 1'b0};

        rst = 1'b1; in_valid = 1'b0; n = '0; d = '0; approx_en = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_q", q, 0);
        chk("reset_r", r, 0);
        chk("reset_flags", {ovf, dbz}, 0);
        $display("reset: in_ready=%0d out_valid=%0d q=%0h r=%0h", in_ready, out_valid, q, r);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].n, vecs[i].d, vecs[i].ae, lat);
            $display("op %0d: n=%0h d=%0h ae=%0d -> q=%0h r=%0h ovf=%0d dbz=%0d lat=%0d",
                     i, vecs[i].n, vecs[i].d, vecs[i].ae, q, r, ovf, dbz, lat);
            chk($sformatf("vec%0d_latency", i), lat, 9);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
            chk($sformatf("vec%0d_in_ready_done", i), in_ready, 0);
`ifdef SEQ_APPROX_DIV_SHADOW_EN
            chk($sformatf("vec%0d_q_exact", i), q_exact, vecs[i].qe);
            chk($sformatf("vec%0d_r_exact", i), r_exact, vecs[i].re);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
`endif
            consume();
            chk($sformatf("vec%0d_released", i), {out_valid, in_ready}, 2'b01);
        end

        // Backpressure: result must hold while out_ready is low.
        run_op(16'd1000, 8'd10, 1'b0, lat);
        hq = q; hr = r;
        chk("bp_first_q", hq, 8'h64);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            $display("stall %0d: out_valid=%0d in_ready=%0d q=%0h r=%0h", c, out_valid, in_ready, q, r);
            chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
            chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
            chk($sformatf("bp%0d_qr", c), {q, r, ovf, dbz}, {8'h64, 8'h00, 2'b00});
        end
        consume();
        chk("bp_release", {out_valid, in_ready}, 2'b01);

        // Reset in the middle of BUSY.
        @(negedge clk);
        n = 16'h1234; d = 8'h03; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {in_ready, out_valid}, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-op reset: in_ready=%0d out_valid=%0d q=%0h r=%0h", in_ready, out_valid, q, r);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_outputs", {q, r, ovf, dbz}, 0);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("rst_mid_no_result", seen, 0);
        end
        run_op(16'd200, 8'd7, 1'b0, lat);
        $display("after reset op: q=%0d r=%0d lat=%0d", q, r, lat);
        chk("post_rst_latency", lat, 9);
        chk("post_rst_q", q, 28);
        chk("post_rst_r", r, 4);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
